// File: rtl/proc_pkg.sv
// Shared definitions for the memory-access / write-back stage: opcode classes,
// FSM state encoding and architectural flag bit positions.
package proc_pkg;

   localparam logic [4:0] OP_LD = 5'b10100;
   localparam logic [4:0] OP_ST = 5'b10101;

   localparam logic [4:0] OP_ALU_A = 5'b10110;
   localparam logic [4:0] OP_ALU_B = 5'b11001;
   localparam logic [4:0] OP_ALU_C = 5'b11010;
   localparam logic [4:0] OP_ALU_D = 5'b11011;

   localparam int FLAG_C = 0;
   localparam int FLAG_Z = 1;
   localparam int FLAG_V = 2;
   localparam int FLAG_P = 3;

   typedef enum logic {
      IDLE     = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      CLS_NOP = 2'd0,
      CLS_ALU = 2'd1,
      CLS_LD  = 2'd2,
      CLS_ST  = 2'd3
   } op_class_t;

   function automatic op_class_t op_class(input logic [4:0] op);
      op_class_t cls;
      cls = CLS_NOP;
      if (!op[4]) begin
         cls = CLS_ALU;
      end else begin
         case (op)
            OP_LD:                                  cls = CLS_LD;
            OP_ST:                                  cls = CLS_ST;
            OP_ALU_A, OP_ALU_B, OP_ALU_C, OP_ALU_D: cls = CLS_ALU;
            default:                                cls = CLS_NOP;
         endcase
      end
      return cls;
   endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Memory-acknowledge watchdog: a down-counter reloaded while cleared that
// flags expiry on the enabled cycle in which it has reached zero.
module mem_timeout_ctr #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= LOAD;
      end else if (clr) begin
         cnt <= LOAD;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   // Expiry lands on the TIMEOUT-th enabled cycle since the last clear.
   assign expire = en && (cnt == '0);

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access / write-back stage: issues loads and stores on a req/ack port,
// drives the register-file write port and the architectural flag register.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | ready for a new instruction; ALU results written back here
// MEM_WAIT | load/store request outstanding, pipeline stalled
module mem_wb_stage
   import proc_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int ADDR_W  = 8,
   parameter int REG_AW  = 3,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4:0]        op_ex,
   input  logic [REG_AW-1:0] rd_ex,
   input  logic [DATA_W-1:0] ans_ex,
   input  logic [DATA_W-1:0] DM_data,
   input  logic [3:0]        flag_ex,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              wb_en,
   output logic [REG_AW-1:0] wb_addr,
   output logic [DATA_W-1:0] wb_data,
   output logic [3:0]        flag_wb,
   output logic              mem_err
);

   state_t            state, state_nxt;
   op_class_t         cls;
   logic              accept;
   logic              alu_wb;
   logic              mem_start;
   logic              ld_done;
   logic              abort;
   logic              ctr_clr;
   logic              ctr_en;
   logic              ctr_expire;
   logic [REG_AW-1:0] rd_q;

   assign in_ready = (state == IDLE);
   assign mem_req  = (state == MEM_WAIT);
   assign cls      = op_class(op_ex);
   assign accept   = in_valid && in_ready;

   mem_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk    (clk),
      .reset  (reset),
      .clr    (ctr_clr),
      .en     (ctr_en),
      .expire (ctr_expire)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      alu_wb    = 1'b0;
      mem_start = 1'b0;
      ld_done   = 1'b0;
      abort     = 1'b0;
      ctr_clr   = 1'b0;
      ctr_en    = 1'b0;
      case (state)
         IDLE: begin
            ctr_clr = 1'b1;
            if (accept) begin
               alu_wb    = (cls == CLS_ALU);
               mem_start = (cls == CLS_LD) || (cls == CLS_ST);
               if (mem_start) begin
                  state_nxt = MEM_WAIT;
               end
            end
         end
         MEM_WAIT: begin
            // An ack on the expiry edge still completes the transaction.
            if (mem_ack) begin
               ld_done   = !mem_we;
               state_nxt = IDLE;
            end else begin
               ctr_en = 1'b1;
               if (ctr_expire) begin
                  abort     = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rd_q      <= '0;
         wb_en     <= 1'b0;
         wb_addr   <= '0;
         wb_data   <= '0;
         flag_wb   <= '0;
         mem_err   <= 1'b0;
      end else begin
         wb_en   <= 1'b0;
         mem_err <= abort;
         if (alu_wb) begin
            wb_en   <= 1'b1;
            wb_addr <= rd_ex;
            wb_data <= ans_ex;
            flag_wb <= flag_ex;
         end
         if (mem_start) begin
            mem_we    <= (cls == CLS_ST);
            mem_addr  <= ans_ex[ADDR_W-1:0];
            mem_wdata <= DM_data;
            rd_q      <= rd_ex;
         end
         if (ld_done) begin
            wb_en   <= 1'b1;
            wb_addr <= rd_q;
            wb_data <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: transaction-level reference model compared
// every cycle, plus hand-computed literal expectations.
module tb_mem_wb_stage;

   localparam int DATA_W  = 8;
   localparam int ADDR_W  = 8;
   localparam int REG_AW  = 3;
   localparam int TIMEOUT = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic [4:0]        op_ex;
   logic [REG_AW-1:0] rd_ex;
   logic [DATA_W-1:0] ans_ex;
   logic [DATA_W-1:0] DM_data;
   logic [3:0]        flag_ex;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;
   logic              wb_en;
   logic [REG_AW-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic [3:0]        flag_wb;
   logic              mem_err;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   mem_wb_stage #(
      .DATA_W (DATA_W), .ADDR_W (ADDR_W), .REG_AW (REG_AW), .TIMEOUT (TIMEOUT)
   ) dut (
      .clk (clk), .reset (reset), .in_valid (in_valid), .in_ready (in_ready),
      .op_ex (op_ex), .rd_ex (rd_ex), .ans_ex (ans_ex), .DM_data (DM_data),
      .flag_ex (flag_ex), .mem_req (mem_req), .mem_we (mem_we),
      .mem_addr (mem_addr), .mem_wdata (mem_wdata), .mem_rdata (mem_rdata),
      .mem_ack (mem_ack), .wb_en (wb_en), .wb_addr (wb_addr),
      .wb_data (wb_data), .flag_wb (flag_wb), .mem_err (mem_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one outstanding memory transaction at most, counted
   // in whole cycles of waiting.
   bit                m_busy, m_is_st, m_wb_en, m_err;
   int                m_waits;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata, m_wb_data;
   logic [REG_AW-1:0] m_rd, m_wb_addr;
   logic [3:0]        m_flag;

   function automatic bit is_alu(input logic [4:0] op);
      int v;
      v = int'(op);
      return (v < 16) || (v == 22) || (v == 25) || (v == 26) || (v == 27);
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_busy = 0; m_is_st = 0; m_wb_en = 0; m_err = 0; m_waits = 0;
         m_addr = '0; m_wdata = '0; m_wb_data = '0; m_rd = '0; m_wb_addr = '0;
         m_flag = '0;
      end else begin
         m_wb_en = 0;
         m_err   = 0;
         if (!m_busy) begin
            if (in_valid) begin
               if (is_alu(op_ex)) begin
                  m_wb_en = 1; m_wb_addr = rd_ex; m_wb_data = ans_ex; m_flag = flag_ex;
               end else if (op_ex == 5'd20 || op_ex == 5'd21) begin
                  m_busy = 1; m_is_st = (op_ex == 5'd21); m_addr = ans_ex;
                  m_wdata = DM_data; m_rd = rd_ex; m_waits = 0;
               end
            end
         end else if (mem_ack) begin
            m_busy = 0;
            if (!m_is_st) begin
               m_wb_en = 1; m_wb_addr = m_rd; m_wb_data = mem_rdata;
            end
         end else begin
            m_waits++;
            if (m_waits == TIMEOUT) begin
               m_busy = 0;
               m_err  = 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("in_ready", in_ready, !m_busy);
      chk("mem_req",  mem_req,  m_busy);
      chk("wb_en",    wb_en,    m_wb_en);
      chk("mem_err",  mem_err,  m_err);
      chk("wb_addr",  wb_addr,  m_wb_addr);
      chk("wb_data",  wb_data,  m_wb_data);
      chk("flag_wb",  flag_wb,  m_flag);
      if (m_busy) begin
         chk("mem_we",    mem_we,    m_is_st);
         chk("mem_addr",  mem_addr,  m_addr);
         chk("mem_wdata", mem_wdata, m_wdata);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [4:0] op, input logic [REG_AW-1:0] rd,
                        input logic [DATA_W-1:0] ans, input logic [DATA_W-1:0] dm,
                        input logic [3:0] fl);
      in_valid = v; op_ex = op; rd_ex = rd; ans_ex = ans; DM_data = dm; flag_ex = fl;
   endtask

   initial begin
      int req_cnt, err_cnt, wb_cnt;
      reset = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
      drive(0, 5'd0, 3'd0, 8'h00, 8'h00, 4'h0);
      step(); step();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_mem_req",  mem_req,  0);
      chk("rst_wb_en",    wb_en,    0);
      chk("rst_flag_wb",  flag_wb,  0);
      reset = 1'b0;
      step();

      // Back-to-back ALU write-backs
      drive(1, 5'b00000, 3'd3, 8'h5A, 8'h00, 4'b1010);
      step();
      drive(1, 5'b10110, 3'd4, 8'h11, 8'h00, 4'b0101);
      chk("alu1_wb_en", wb_en, 1);
      chk("alu1_addr",  wb_addr, 3);
      chk("alu1_data",  wb_data, 8'h5A);
      chk("alu1_flag",  flag_wb, 4'b1010);
      step();
      drive(0, 5'd0, 3'd0, 8'h00, 8'h00, 4'h0);
      chk("alu2_wb_en", wb_en, 1);
      chk("alu2_data",  wb_data, 8'h11);
      chk("alu2_flag",  flag_wb, 4'b0101);
      step();
      chk("alu_idle_wb_en", wb_en, 0);

      // Load acked after two waiting cycles
      drive(1, 5'b10100, 3'd5, 8'h20, 8'h00, 4'hF);
      step();
      drive(0, 5'd0, 3'd0, 8'h00, 8'h00, 4'h0);
      chk("ld_req",      mem_req, 1);
      chk("ld_addr",     mem_addr, 8'h20);
      chk("ld_we",       mem_we, 0);
      chk("ld_in_ready", in_ready, 0);
      step(); step();
      mem_ack = 1'b1; mem_rdata = 8'hC3;
      step();
      mem_ack = 1'b0; mem_rdata = 8'h00;
      chk("ld_wb_en",   wb_en, 1);
      chk("ld_wb_addr", wb_addr, 5);
      chk("ld_wb_data", wb_data, 8'hC3);
      chk("ld_model",   m_wb_data, 8'hC3);
      chk("ld_flag",    flag_wb, 4'b0101);
      chk("ld_ready",   in_ready, 1);

      // Store acked in its first request cycle
      drive(1, 5'b10101, 3'd1, 8'h40, 8'h99, 4'h0);
      step();
      drive(0, 5'd0, 3'd0, 8'h00, 8'h00, 4'h0);
      mem_ack = 1'b1;
      chk("st_we",    mem_we, 1);
      chk("st_wdata", mem_wdata, 8'h99);
      chk("st_addr",  mem_addr, 8'h40);
      step();
      mem_ack = 1'b0;
      chk("st_no_wb", wb_en, 0);
      chk("st_ready", in_ready, 1);
      chk("st_req",   mem_req, 0);

      // Load never acked: timeout, then a late ack that must be ignored
      drive(1, 5'b10100, 3'd6, 8'h33, 8'h00, 4'h0);
      step();
      drive(0, 5'd0, 3'd0, 8'h00, 8'h00, 4'h0);
      req_cnt = 0; err_cnt = 0; wb_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         if (mem_req) req_cnt++;
         if (mem_err) err_cnt++;
         if (wb_en)   wb_cnt++;
         if (i == 4) chk("to_err_pulse", mem_err, 1);
         mem_ack = (i == 5);
         step();
      end
      mem_ack = 1'b0;
      chk("to_req_cycles", req_cnt, 4);
      chk("to_err_count",  err_cnt, 1);
      chk("to_no_wb",      wb_cnt, 0);

      // NOP opcode, then stalled inputs during MEM_WAIT
      drive(1, 5'b10000, 3'd2, 8'hAA, 8'h00, 4'b1111);
      step();
      chk("nop_wb_en", wb_en, 0);
      chk("nop_flag",  flag_wb, 4'b0101);
      drive(1, 5'b10100, 3'd7, 8'h50, 8'h00, 4'h0);
      step();
      drive(1, 5'b00001, 3'd2, 8'hEE, 8'h00, 4'b0011);
      step(); step();
      chk("stall_wb_en", wb_en, 0);
      chk("stall_addr",  mem_addr, 8'h50);
      mem_ack = 1'b1; mem_rdata = 8'h7E;
      step();
      mem_ack = 1'b0;
      chk("stall_ld_data", wb_data, 8'h7E);
      chk("stall_ld_addr", wb_addr, 7);
      step();
      drive(0, 5'd0, 3'd0, 8'h00, 8'h00, 4'h0);
      chk("resume_wb_data", wb_data, 8'hEE);
      chk("resume_flag",    flag_wb, 4'b0011);
      step();

      // Reset asserted while a load is outstanding
      drive(1, 5'b10100, 3'd1, 8'h60, 8'h00, 4'h0);
      step();
      drive(0, 5'd0, 3'd0, 8'h00, 8'h00, 4'h0);
      chk("pre_rst_req", mem_req, 1);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_req",   mem_req, 0);
      chk("mid_rst_ready", in_ready, 1);
      chk("mid_rst_wb_en", wb_en, 0);
      chk("mid_rst_err",   mem_err, 0);
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      reset = 1'b0;
      step(); step();
      chk("post_rst_wb_en", wb_en, 0);
      chk("post_rst_err",   mem_err, 0);
      chk("post_rst_flag",  flag_wb, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access / write-back stage that consumes the execution block's registered outputs: result `ans_ex`, store data `DM_data`, flags `flag_ex`, plus the opcode and destination register carried alongside.
- Performs loads and stores through a req/ack data-memory port and drives the register-file write port and the architectural flag register.
- Back-pressures the pipeline with `in_ready` while a memory transaction is outstanding.

Parameters:
- DATA_W, 8, datapath and memory word width
- ADDR_W, 8, data-memory address width, taken from `ans_ex[ADDR_W-1:0]`
- REG_AW, 3, register-file address width
- TIMEOUT, 255, cycles to wait for `mem_ack` before aborting (1..255)

Ports:
- clk  in  1  single clock, all state updates on posedge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  execution stage presents an instruction
- in_ready  out  1  stage can accept; high only in IDLE
- op_ex  in  5  opcode of the instruction in execution
- rd_ex  in  REG_AW  destination register
- ans_ex  in  DATA_W  ALU result, or memory address for LD/ST
- DM_data  in  DATA_W  store data
- flag_ex  in  4  {parity, overflow, zero, carry}
- mem_req  out  1  memory request, held until acknowledged
- mem_we  out  1  1 = store, 0 = load
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  store data
- mem_rdata  in  DATA_W  load data, valid with `mem_ack`
- mem_ack  in  1  transaction complete
- wb_en  out  1  register-file write strobe, one cycle
- wb_addr  out  REG_AW  write address
- wb_data  out  DATA_W  write data
- flag_wb  out  4  architectural flag register
- mem_err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset: state = IDLE. All outputs 0 except `in_ready`, which is 1. Timeout counter cleared.
- Reset asserted mid-transaction: `mem_req` drops immediately, no write-back, no `mem_err`.
- Op classes (package constants):
  - LD = 10100, ST = 10101.
  - ALU_WB = 00000–01111, 10110, 11001, 11011, 11010.
  - All other opcodes are NOP: no write-back, flags unchanged.
- Acceptance happens only on a cycle where `in_valid && in_ready`. Inputs are ignored otherwise.
- ALU_WB accepted at edge N:
  - at edge N+1, `wb_en`=1, `wb_addr`=`rd_ex`, `wb_data`=`ans_ex`, `flag_wb`=`flag_ex`.
  - latency 1, state stays IDLE, back-to-back acceptance allowed.
- LD/ST accepted at edge N:
  - at edge N+1, state = MEM_WAIT; `mem_req`=1, `mem_we`=(op==ST), `mem_addr`=`ans_ex`, `mem_wdata`=`DM_data`.
  - `rd_ex` is latched.
  - `in_ready`=0 throughout MEM_WAIT.
  - Request fields are stable while `mem_req`=1.
- MEM_WAIT with `mem_ack`=1, sampled at an edge:
  - `mem_req` drops at that edge.
  - For LD: `wb_data`=`mem_rdata`, `wb_addr`=latched rd, `wb_en`=1 for that following cycle.
  - For ST: no write-back.
  - Next state is IDLE, so `in_ready`=1 again the cycle after the ack.
  - Minimum LD: accept N, ack sampled N+2, `wb_en` N+2..N+3.
- `mem_ack` while `mem_req`=0 is ignored.
- LD/ST do not modify `flag_wb`.
- Timeout:
  - Counter increments each MEM_WAIT cycle without ack.
  - When the count reaches TIMEOUT: `mem_req` drops, `mem_err` pulses one cycle, no write-back, state returns to IDLE.
  - An ack on the same edge as the timeout wins: the transaction completes normally.
- `wb_en` and `mem_err` are single-cycle pulses; `wb_addr`/`wb_data` hold their last values otherwise.

Decomposition:
- Shared package `proc_pkg`: opcode constants (OP_LD, OP_ST, ALU write-back list), state encoding {IDLE, MEM_WAIT}, flag bit indices.
- One sub-module, `mem_timeout_ctr`: clear/enable/expire, width derived from TIMEOUT.
- Remaining logic (FSM, request registers, write-back registers) stays in `mem_wb_stage`.

Test Plan:
- Reset mid-LD: reset asserted while `mem_req`=1 -> `mem_req`=0 asynchronously, `in_ready`=1, no `wb_en`, no `mem_err`.
- ALU op 00000, rd=3, ans=0x5A, flag=1010 -> next cycle `wb_en`=1, addr 3, data 0x5A, `flag_wb`=1010; second op the following cycle -> `wb_en` high two consecutive cycles.
- LD, rd=5, ans=0x20; memory acks 3 cycles later with rdata 0xC3 -> `mem_addr`=0x20, `mem_we`=0, `in_ready`=0 until ack; `wb_en` with addr 5, data 0xC3; `flag_wb` unchanged.
- ST, ans=0x40, DM_data=0x99, ack in first request cycle -> `mem_we`=1, `mem_wdata`=0x99, no `wb_en`, `in_ready`=1 the cycle after the ack.
- TIMEOUT=4, LD never acked -> `mem_req` high exactly 4 cycles, `mem_err` 1-cycle pulse, no `wb_en`; ack arriving afterwards ignored.
- Opcode 10000 with `in_valid`=1; also `in_valid`=1 during MEM_WAIT -> no `wb_en`, flags unchanged, stalled inputs not accepted.
